// File: rtl/dsa_pkg.sv
// rtl/dsa_pkg.sv - shared types and helpers for the SIMD writeback block
package dsa_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } drain_state_t;

  typedef logic [7:0] pixel_t;

  localparam int MAX_SIMD   = 16;
  localparam int LANE_CNT_W = 5;

  // Lanes of a group that fall inside the output row; lanes past the row end are dropped.
  function automatic logic [LANE_CNT_W-1:0] valid_lanes(
    input logic [15:0] x,
    input logic [15:0] width,
    input int          simd
  );
    logic [15:0] span;
    valid_lanes = '0;
    span = width - x;
    if (x < width) begin
      if (span >= 16'(simd)) valid_lanes = LANE_CNT_W'(simd);
      else                   valid_lanes = LANE_CNT_W'(span);
    end
  endfunction

endpackage

// File: rtl/dsa_wb_group_fifo.sv
// rtl/dsa_wb_group_fifo.sv - two-entry FIFO of captured result groups
module dsa_wb_group_fifo
  import dsa_pkg::*;
#(
  parameter int SIMD_WIDTH = 4,
  parameter int ADDR_WIDTH = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [SIMD_WIDTH*8-1:0] push_pixels,
  input  logic [LANE_CNT_W-1:0]   push_lanes,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic                    pop,
  output logic [SIMD_WIDTH*8-1:0] head_pixels,
  output logic [LANE_CNT_W-1:0]   head_lanes,
  output logic [ADDR_WIDTH-1:0]   head_addr,
  output logic [1:0]              occupancy
);

  logic [SIMD_WIDTH*8-1:0] pix_mem   [2];
  logic [LANE_CNT_W-1:0]   lanes_mem [2];
  logic [ADDR_WIDTH-1:0]   addr_mem  [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic                    do_pop;

  assign do_pop = pop && (occupancy != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (do_pop) rd_ptr <= ~rd_ptr;
      occupancy <= occupancy + {1'b0, push} - {1'b0, do_pop};
    end
  end

  // Payload needs no reset: occupancy alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (push) begin
      pix_mem[wr_ptr]   <= push_pixels;
      lanes_mem[wr_ptr] <= push_lanes;
      addr_mem[wr_ptr]  <= push_addr;
    end
  end

  assign head_pixels = pix_mem[rd_ptr];
  assign head_lanes  = lanes_mem[rd_ptr];
  assign head_addr   = addr_mem[rd_ptr];

endmodule

// File: rtl/dsa_simd_writeback.sv
// rtl/dsa_simd_writeback.sv - buffers SIMD result groups and writes them to memory one byte per cycle
module dsa_simd_writeback
  import dsa_pkg::*;
#(
  parameter int          ADDR_WIDTH = 18,
  parameter int          SIMD_WIDTH = 4,
  parameter int          MEM_SIZE   = 262144,
  parameter int          OUT_BASE   = MEM_SIZE / 2,
  parameter logic [31:0] COUNT_INIT = 32'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dp_done,
  input  logic [SIMD_WIDTH*8-1:0] dp_pixel,
  input  logic [15:0]             grp_x,
  input  logic [15:0]             grp_y,
  input  logic [15:0]             img_width_out,
  input  logic                    ext_access,
  input  logic                    clear_count,
  output logic                    wb_ready,
  output logic                    mem_write_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [7:0]              mem_data,
  output logic                    wb_busy,
  output logic                    group_done,
  output logic                    overflow,
  output logic [31:0]             writes_count
);

  if (SIMD_WIDTH < 1 || SIMD_WIDTH > MAX_SIMD || OUT_BASE >= MEM_SIZE) begin : g_param_check
    $error("dsa_simd_writeback: illegal parameter combination");
  end

  logic [SIMD_WIDTH*8-1:0] head_pixels;
  logic [LANE_CNT_W-1:0]   head_lanes;
  logic [LANE_CNT_W-1:0]   capture_lanes;
  logic [LANE_CNT_W-1:0]   lane;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [ADDR_WIDTH-1:0]   capture_addr;
  logic [1:0]              occupancy;
  logic [1:0]              occ_next;
  drain_state_t            state;
  logic                    accept;
  logic                    drain;
  logic                    last_lane;
  logic                    issue;
  logic                    pop;
  logic                    overflow_q;
  logic [31:0]             count_q;
  pixel_t                  lane_pixel;

  assign capture_lanes = valid_lanes(grp_x, img_width_out, SIMD_WIDTH);
  assign capture_addr  = ADDR_WIDTH'(OUT_BASE)
                       + ADDR_WIDTH'(32'(grp_y) * 32'(img_width_out))
                       + ADDR_WIDTH'(grp_x);

  assign wb_ready = occupancy < 2'd2;
  assign accept   = dp_done && wb_ready;

  dsa_wb_group_fifo #(
    .SIMD_WIDTH (SIMD_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_group_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (accept),
    .push_pixels (dp_pixel),
    .push_lanes  (capture_lanes),
    .push_addr   (capture_addr),
    .pop         (pop),
    .head_pixels (head_pixels),
    .head_lanes  (head_lanes),
    .head_addr   (head_addr),
    .occupancy   (occupancy)
  );

  // ext_access gates the strobe combinationally so the host owns the bus in the very cycle it asks.
  assign drain      = (state == ST_WRITE) && (occupancy != 2'd0);
  assign last_lane  = lane == (head_lanes - LANE_CNT_W'(1));
  assign issue      = drain && (head_lanes != '0) && !ext_access;
  assign pop        = drain && ((head_lanes == '0) || (issue && last_lane));
  assign occ_next   = occupancy + {1'b0, accept} - {1'b0, pop};
  assign lane_pixel = head_pixels[8*int'(lane) +: 8];

  assign mem_write_en = issue;
  assign mem_addr     = issue ? head_addr + ADDR_WIDTH'(lane) : '0;
  assign mem_data     = issue ? lane_pixel : 8'd0;
  assign group_done   = pop;
  assign wb_busy      = (occupancy != 2'd0) || (state == ST_WRITE);
  assign overflow     = overflow_q;
  assign writes_count = count_q;

  // Entering WRITE on the capture edge lets lane 0 go out in the very next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      lane       <= '0;
      overflow_q <= 1'b0;
      count_q    <= COUNT_INIT;
    end else begin
      state <= (occ_next != 2'd0) ? ST_WRITE : ST_IDLE;
      if (pop)        lane <= '0;
      else if (issue) lane <= lane + LANE_CNT_W'(1);
      if (dp_done && !wb_ready) overflow_q <= 1'b1;
      if (clear_count)                 count_q <= {31'd0, issue};
      else if (issue && count_q != '1) count_q <= count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_dsa_simd_writeback.sv
// tb/tb_dsa_simd_writeback.sv - scoreboard bench for dsa_simd_writeback
module tb_dsa_simd_writeback;

  typedef struct {
    bit          is_write;
    logic [17:0] addr;
    logic [7:0]  data;
    bit          last;
  } exp_t;

  typedef struct {
    logic [17:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dp_done;
  logic [31:0] dp_pixel;
  logic [15:0] grp_x, grp_y, img_width_out;
  logic        ext_access, clear_count;
  logic        wb_ready, mem_write_en, wb_busy, group_done, overflow;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic [31:0] writes_count;
  logic        s_wb_ready, s_mem_write_en, s_wb_busy, s_group_done, s_overflow;
  logic [17:0] s_mem_addr;
  logic [7:0]  s_mem_data;
  logic [31:0] s_writes_count;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mq[$];
  exp_t        expq[$];
  wr_t         wlog[$];
  int          dlog[$];
  logic [31:0] wc_m, sat_m;
  bit          ovf_m;
  exp_t        mon_e;
  wr_t         mon_w;
  int          t;

  dsa_simd_writeback dut (
    .clk(clk), .rst(rst), .dp_done(dp_done), .dp_pixel(dp_pixel), .grp_x(grp_x), .grp_y(grp_y),
    .img_width_out(img_width_out), .ext_access(ext_access), .clear_count(clear_count),
    .wb_ready(wb_ready), .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_busy(wb_busy), .group_done(group_done), .overflow(overflow), .writes_count(writes_count)
  );

  dsa_simd_writeback #(.COUNT_INIT(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst(rst), .dp_done(dp_done), .dp_pixel(dp_pixel), .grp_x(grp_x), .grp_y(grp_y),
    .img_width_out(img_width_out), .ext_access(ext_access), .clear_count(1'b0),
    .wb_ready(s_wb_ready), .mem_write_en(s_mem_write_en), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .wb_busy(s_wb_busy), .group_done(s_group_done), .overflow(s_overflow), .writes_count(s_writes_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: groups are lists of remaining bytes; one byte leaves the head per free cycle.
  task automatic model_step();
    bit          ready, issued, done;
    int          v;
    longint      a;
    logic [31:0] pix;
    exp_t        e;
    ready = (mq.size() < 2);
    chk("wb_ready", wb_ready, ready);
    chk("wb_busy", wb_busy, mq.size() > 0);
    chk("overflow", overflow, ovf_m);
    chk("writes_count", writes_count, wc_m);
    chk("sat_writes_count", s_writes_count, sat_m);
    issued = 0;
    done = 0;
    if (mq.size() > 0) begin
      if (mq[0] == 0) done = 1;
      else if (!ext_access) begin
        issued = 1;
        mq[0] = mq[0] - 1;
        done = (mq[0] == 0);
      end
    end
    chk("mem_write_en", mem_write_en, issued);
    chk("group_done", group_done, done);
    if (!issued) begin
      chk("idle_mem_addr", mem_addr, 0);
      chk("idle_mem_data", mem_data, 0);
    end
    if (done) void'(mq.pop_front());
    if (dp_done) begin
      if (ready) begin
        if (grp_x >= img_width_out) v = 0;
        else v = (int'(img_width_out) - int'(grp_x) < 4) ? int'(img_width_out) - int'(grp_x) : 4;
        a = (longint'(131072) + longint'(grp_y) * longint'(img_width_out) + longint'(grp_x)) % 262144;
        mq.push_back(v);
        pix = dp_pixel;
        if (v == 0) begin
          e.is_write = 0; e.addr = 0; e.data = 0; e.last = 1;
          expq.push_back(e);
        end
        for (int i = 0; i < v; i++) begin
          e.is_write = 1;
          e.addr = 18'((a + i) % 262144);
          e.data = pix[8*i +: 8];
          e.last = (i == v - 1);
          expq.push_back(e);
        end
      end else ovf_m = 1;
    end
    if (clear_count) wc_m = {31'd0, issued};
    else if (issued && wc_m != 32'hFFFF_FFFF) wc_m = wc_m + 1;
    if (issued && sat_m != 32'hFFFF_FFFF) sat_m = sat_m + 1;
  endtask

  // Monitor: every write or completion must match the next expected scoreboard entry.
  always @(negedge clk) begin
    if (!rst && (mem_write_en || group_done)) begin
      if (mem_write_en) begin
        mon_w.addr = mem_addr; mon_w.data = mem_data; mon_w.cyc = cyc;
        wlog.push_back(mon_w);
      end
      if (group_done) dlog.push_back(cyc);
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: actual we=%0d done=%0d required=no output", mem_write_en, group_done);
      end else begin
        mon_e = expq.pop_front();
        chk("sb_kind", mem_write_en, mon_e.is_write);
        if (mon_e.is_write) begin
          chk("sb_addr", mem_addr, mon_e.addr);
          chk("sb_data", mem_data, mon_e.data);
        end
        chk("sb_last", group_done, mon_e.last);
      end
    end
  end

  task automatic cycle(input bit dp, input logic [31:0] pix, input logic [15:0] x, input logic [15:0] y,
                       input bit ext, input bit clr);
    dp_done = dp; dp_pixel = pix; grp_x = x; grp_y = y; ext_access = ext; clear_count = clr;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    dp_done = 0; ext_access = 0; clear_count = 0;
  endtask

  task automatic idle();
    cycle(0, 32'd0, 16'd0, 16'd0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0) break;
      idle();
    end
    chk("drained_busy", wb_busy, 0);
  endtask

  task automatic clear_logs();
    wlog.delete();
    dlog.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, mem_write_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
    chk({tag, "_busy"}, wb_busy, 0);
    chk({tag, "_done"}, group_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_count"}, writes_count, 0);
    chk({tag, "_ready"}, wb_ready, 1);
    chk({tag, "_sat"}, s_writes_count, 32'hFFFF_FFFE);
  endtask

  initial begin
    rst = 1; dp_done = 0; dp_pixel = 0; grp_x = 0; grp_y = 0;
    img_width_out = 16'd64; ext_access = 0; clear_count = 0;
    wc_m = 0; sat_m = 32'hFFFF_FFFE; ovf_m = 0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 0;

    // Single group at (8,2) in a 64-wide row.
    clear_logs();
    t = cyc;
    cycle(1, {8'd40, 8'd30, 8'd20, 8'd10}, 16'd8, 16'd2, 0, 0);
    repeat (5) idle();
    chk("single_nwrites", wlog.size(), 4);
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("single_addr", wlog[i].addr, 131208 + i);
        chk("single_data", wlog[i].data, 10 * (i + 1));
        chk("single_cycle", wlog[i].cyc, t + 1 + i);
      end
    chk("single_done_cycle", (dlog.size() == 1) ? dlog[0] : -1, t + 4);
    chk("single_count", writes_count, 4);
    chk("sat_count", s_writes_count, 32'hFFFF_FFFF);

    // Tail group: only two lanes fit in a 6-wide row.
    img_width_out = 16'd6;
    clear_logs();
    t = cyc;
    cycle(1, 32'hA1B2C3D4, 16'd4, 16'd1, 0, 0);
    repeat (4) idle();
    chk("tail_nwrites", wlog.size(), 2);
    chk("tail_done_cycle", (dlog.size() == 1) ? dlog[0] : -1, t + 2);

    // Fully out-of-row group: completes with no writes.
    clear_logs();
    t = cyc;
    cycle(1, 32'h11223344, 16'd9, 16'd0, 0, 0);
    repeat (3) idle();
    chk("empty_nwrites", wlog.size(), 0);
    chk("empty_done_cycle", (dlog.size() == 1) ? dlog[0] : -1, t + 1);

    // Back-to-back groups: third arrives while the buffer is full.
    img_width_out = 16'd64;
    clear_logs();
    t = cyc;
    cycle(1, 32'h04030201, 16'd0, 16'd0, 0, 0);
    cycle(1, 32'h08070605, 16'd4, 16'd0, 0, 0);
    cycle(1, 32'h0C0B0A09, 16'd8, 16'd0, 0, 0);
    repeat (10) idle();
    chk("b2b_nwrites", wlog.size(), 8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++) chk("b2b_gapfree", wlog[i].cyc, t + 1 + i);
    chk("b2b_overflow", overflow, 1);

    // Three-cycle stall while lane 1 is pending.
    clear_logs();
    t = cyc;
    cycle(1, 32'h44332211, 16'd16, 16'd1, 0, 0);
    idle();
    repeat (3) cycle(0, 32'd0, 16'd0, 16'd0, 1, 0);
    repeat (6) idle();
    chk("stall_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("stall_lane1_cycle", wlog[1].cyc, t + 5);
      chk("stall_lane1_addr", wlog[1].addr, 131153);
      chk("stall_last_cycle", wlog[3].cyc, t + 7);
    end

    // Counter clear coinciding with a write.
    cycle(1, 32'h55667788, 16'd0, 16'd3, 0, 0);
    cycle(0, 32'd0, 16'd0, 16'd0, 0, 1);
    chk("clear_with_write", writes_count, 1);
    drain();

    // Asynchronous reset after lane 2 of a group.
    cycle(1, 32'h99AABBCC, 16'd0, 16'd5, 0, 0);
    repeat (3) idle();
    #2;
    rst = 1;
    #1;
    check_reset_outputs("midreset");
    mq.delete(); expq.delete(); clear_logs();
    wc_m = 0; sat_m = 32'hFFFF_FFFE; ovf_m = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (6) idle();
    chk("post_reset_nwrites", wlog.size(), 0);

    // Randomized traffic in a 40-wide row with stalls, tails, empty groups and address wrap.
    img_width_out = 16'd40;
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 2) == 0, $urandom, 16'($urandom_range(0, 44)), 16'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    drain();
    idle();
    chk("scoreboard_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dsa_simd_writeback.md
DSA_SIMD_WRITEBACK -- requirements
Module: dsa_simd_writeback

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 18: memory address width.
REQ-002 SHALL have parameter SIMD_WIDTH, default 4, legal 1..16: lanes per result group.
REQ-003 SHALL have parameter MEM_SIZE, default 262144: total memory bytes.
REQ-004 SHALL have parameter OUT_BASE, default MEM_SIZE/2: output image base address.
REQ-005 SHALL have ports:
- clk  in  1  clock; one clock domain, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dp_done  in  1  pulse; lane results valid.
- dp_pixel  in  SIMD_WIDTH*8  lane i at bits [8i+7:8i].
- grp_x  in  16  output x of lane 0.
- grp_y  in  16  output y of lane 0.
- img_width_out  in  16  output row width; held stable while wb_busy=1.
- ext_access  in  1  host owns memory this cycle.
- clear_count  in  1  synchronous counter clear.
- wb_ready  out  1  a group can be accepted.
- mem_write_en  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_data  out  8  write data.
- wb_busy  out  1  a group is queued or draining.
- group_done  out  1  pulse; a group has finished.
- overflow  out  1  sticky; a group was dropped.
- writes_count  out  32  count of issued writes.

Function
REQ-006 SHALL buffer up to 2 groups in FIFO order; wb_ready = (occupancy < 2), combinational.
REQ-007 SHALL capture on dp_done=1 with wb_ready=1: all lanes, valid-lane count V, and base address A.
- V = min(SIMD_WIDTH, img_width_out - grp_x); V = 0 when grp_x >= img_width_out.
- A = OUT_BASE + grp_y*img_width_out + grp_x, truncated to ADDR_WIDTH.
REQ-008 SHALL drop a group on dp_done=1 with wb_ready=0, set overflow, and leave buffer contents unchanged.
REQ-009 SHALL use drain FSM states IDLE and WRITE.
- IDLE->WRITE when occupancy > 0.
- WRITE->IDLE after the last lane write when no other group is queued.
- WRITE->WRITE (next group, lane 0, no bubble) when another group is queued.
REQ-010 SHALL in WRITE with ext_access=0 assert mem_write_en with mem_addr = A + lane and mem_data = that lane's pixel, then advance lane by 1.
REQ-011 SHALL in WRITE with ext_access=1 hold mem_write_en=0 and hold the lane index (stall, no write lost).
REQ-012 SHALL issue the first write of a group captured at cycle t no earlier than t+1.
- A lone group with no stalls occupies write cycles t+1 .. t+V.
REQ-013 SHALL pulse group_done for one cycle in the cycle of a group's last write, then pop the group.
REQ-014 SHALL pop a V=0 group with zero writes and pulse group_done one cycle after it reaches the head.
REQ-015 SHALL accept a capture and a pop in the same cycle; occupancy stays unchanged.
REQ-016 SHALL wrap address arithmetic modulo 2^ADDR_WIDTH with no error flag.
REQ-017 SHALL increment writes_count by 1 per issued write and saturate at 2^32-1.
REQ-018 SHALL on clear_count=1 reload writes_count with 1 if a write issues that cycle, else 0.
REQ-019 SHALL drive wb_busy = (occupancy > 0) or (state == WRITE).
REQ-020 SHALL drive mem_addr and mem_data to 0 whenever mem_write_en=0.

Reset
REQ-021 SHALL on rst=1, immediately and asynchronously:
- set occupancy 0, state IDLE, lane index 0;
- set mem_write_en, wb_busy, group_done, overflow, writes_count, mem_addr, mem_data to 0;
- set wb_ready to 1.
REQ-022 SHALL discard groups that are mid-drain at reset; no further writes for them after reset.

Structure
REQ-023 SHALL place the drain state enum and the lane-pixel type in the shared package dsa_pkg.
REQ-024 SHALL implement the 2-entry group buffer as sub-module dsa_wb_group_fifo, parameterised by SIMD_WIDTH and ADDR_WIDTH.

Verification
REQ-025 Single group (SIMD_WIDTH=4, OUT_BASE=131072, width 64, grp=(8,2), pixels 10,20,30,40):
- writes at 131208..131211 with data 10,20,30,40 in 4 consecutive cycles;
- group_done with the 4th write; writes_count=4.
REQ-026 Tail group (width 6, grp_x=4): exactly 2 writes (lanes 0,1); group_done pulses.
REQ-027 Back-to-back groups (dp_done at t, t+1, t+2):
- t+2 is accepted because the 2-entry buffer was full only while no pop was pending, or is dropped;
- the bench checks that overflow=1 iff a dp_done arrived with wb_ready=0;
- writes are gap-free across groups.
REQ-028 Stall: ext_access=1 for 3 cycles during lane 1:
- no write for those 3 cycles;
- lane 1 is written next with the correct address;
- total latency grows by exactly 3.
REQ-029 Reset mid-drain after lane 2:
- all outputs 0 and wb_ready=1 in the same cycle;
- no writes after reset until a new dp_done.
REQ-030 Counter:
- clear_count in the same cycle as a write gives writes_count=1;
- preloaded 2^32-2 plus 3 writes gives 2^32-1.
